// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: datapath width, canonical NOP, buffer occupancy
// encoding and the pipe-entry record carried from fetch into decode.
// Pure definitions; no timing or flow control.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } pipe_entry_t;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_entry.sv
// Single loadable pipe-entry register; clear returns it to the canonical empty (NOP) value.
// Latency: load visible one cycle later. Reset outranks clear, clear outranks load.
// Backpressure: none; the parent decides when to load or clear.
module if_id_entry
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] CLR_INSTR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        ld,
    input  pipe_entry_t d,
    output pipe_entry_t q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q.valid      <= 1'b0;
            q.pc         <= '0;
            q.instr      <= CLR_INSTR;
            q.misaligned <= 1'b0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry elastic IF/ID buffer (head + skid) with flush and NOP on empty slots.
// Latency: accepted pair is on the outputs the next cycle; 1 entry/cycle when decode is ready.
// Backpressure: in_ready is registered (!skid.valid), so one extra entry is absorbed after a stall.
module if_id_buffer #(
    parameter int          XLEN      = riscv_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            out_misaligned,
    output logic [1:0]      occupancy
);

    import riscv_pkg::*;

    occ_t        occ, occ_nxt;
    pipe_entry_t head_q, skid_q, head_d, in_entry;
    logic        head_ld, head_clr, skid_ld, skid_clr;
    logic        accept, pop;

    assign in_ready = ~skid_q.valid;
    assign accept   = in_valid & in_ready;
    assign pop      = head_q.valid & out_ready;

    assign in_entry.valid      = 1'b1;
    assign in_entry.pc         = in_pc;
    assign in_entry.instr      = in_instr;
    assign in_entry.misaligned = pc_misaligned(in_pc);

    always_comb begin
        occ_nxt  = occ;
        head_d   = in_entry;
        head_ld  = 1'b0;
        head_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            // a same-cycle pop is still consumed by decode; nothing else survives
            head_clr = 1'b1;
            skid_clr = 1'b1;
            occ_nxt  = OCC_EMPTY;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_ld = 1'b1;
                        occ_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        occ_nxt = OCC_FULL;
                    end else if (pop) begin
                        head_clr = 1'b1;
                        occ_nxt  = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_d   = skid_q;
                        head_ld  = 1'b1;
                        skid_clr = 1'b1;
                        occ_nxt  = OCC_ONE;
                    end
                end
                default: begin
                    head_clr = 1'b1;
                    skid_clr = 1'b1;
                    occ_nxt  = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= OCC_EMPTY;
        end else begin
            occ <= occ_nxt;
        end
    end

    if_id_entry #(.CLR_INSTR(NOP_INSTR)) u_head (
        .clk   (clk),
        .reset (reset),
        .clr   (head_clr),
        .ld    (head_ld),
        .d     (head_d),
        .q     (head_q)
    );

    if_id_entry #(.CLR_INSTR(NOP_INSTR)) u_skid (
        .clk   (clk),
        .reset (reset),
        .clr   (skid_clr),
        .ld    (skid_ld),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign out_valid      = head_q.valid;
    assign out_pc         = head_q.pc;
    assign out_instr      = head_q.instr;
    assign out_misaligned = head_q.misaligned;
    assign occupancy      = occ;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer with a scoreboard queue of expected head entries.
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready, out_misaligned;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic [1:0]  occupancy;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic last_acc;

    always #5 clk = ~clk;

    if_id_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misaligned (out_misaligned),
        .occupancy      (occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz = q.size();
        chk("occupancy", 32'(occupancy), 32'(sz));
        chk("in_ready", 32'(in_ready), 32'(sz < 2));
        chk("out_valid", 32'(out_valid), 32'(sz > 0));
        if (sz == 0) begin
            chk("empty_pc", out_pc, 32'h0);
            chk("empty_instr", out_instr, NOP);
            chk("empty_mis", 32'(out_misaligned), 32'h0);
        end else begin
            chk("head_pc", out_pc, q[0].pc);
            chk("head_instr", out_instr, q[0].instr);
            chk("head_mis", 32'(out_misaligned), 32'(q[0].mis));
        end
    endtask

    // One clock: check outputs mid-cycle, update the model with this cycle's
    // handshakes, then advance to just after the next rising edge.
    task automatic step();
        exp_t e;
        int   sz;
        @(negedge clk);
        last_acc = 1'b0;
        if (reset) begin
            q.delete();
        end else begin
            check_state();
            sz = q.size();
            last_acc = in_valid && (sz < 2);
            if (out_ready && sz > 0) void'(q.pop_front());
            if (flush) begin
                q.delete();
                last_acc = 1'b0;
            end else if (last_acc) begin
                e.pc    = in_pc;
                e.instr = in_instr;
                e.mis   = (in_pc[1:0] != 2'b00);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
    endtask

    initial begin
        logic [31:0] pcs[3];
        int          idx;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'hdead_beef);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_instr", out_instr, NOP);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        reset = 1'b0;
        q.delete();

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 32'h0050_0093 + 32'(i << 20));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) step();

        // stall with the skid absorbing one extra entry, then release
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(idx < 3, (idx < 3) ? pcs[idx] : 32'h0, 32'h1000_0000 + 32'(idx));
            step();
            if (last_acc) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'h2);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(idx < 3, (idx < 3) ? pcs[idx] : 32'h0, 32'h1000_0000 + 32'(idx));
            step();
            if (last_acc) idx++;
        end
        chk("stall_all_fed", 32'(idx), 32'h3);

        // flush while full, with a valid input dropped
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 32'h0010_0113); step();
        drive(1'b1, 32'h24, 32'h0020_0193); step();
        drive(1'b1, 32'h10, 32'h0030_0213);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        repeat (3) step();

        // misaligned entry followed by an aligned one
        drive(1'b1, 32'h6, 32'h00a0_0293); step();
        chk("mis_flag", 32'(out_misaligned), 32'h1);
        chk("mis_pc", out_pc, 32'h6);
        drive(1'b1, 32'h8, 32'h00b0_0313); step();
        chk("aligned_flag", 32'(out_misaligned), 32'h0);
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) step();

        // reset while full with flush asserted, then a fresh accept
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 32'h0011_0113); step();
        drive(1'b1, 32'h34, 32'h0022_0113); step();
        reset = 1'b1; flush = 1'b1;
        drive(1'b1, 32'h38, 32'h0033_0113);
        step();
        reset = 1'b0; flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h40, 32'h0044_0113);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("post_rst_pc", out_pc, 32'h40);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry elastic pipeline buffer between the fetch stage (ProgramCounter, PC_Adder, instr_mem) and the decode stage. Captures each fetched PC/instruction pair and presents it to decode one cycle later. Decouples decode back-pressure from fetch through a skid entry, and supports a one-cycle flush for taken branches and jumps. Empty slots present a canonical NOP so decode always sees a legal encoding.

## Interface
Parameters:
- XLEN, 32, PC and instruction width
- NOP_INSTR, 32'h00000013, value driven on out_instr when no entry is valid (addi x0,x0,0)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset sampled on rising edge of clk
- in_valid  input  1  fetch presents a valid pair
- in_ready  output  1  buffer can accept this cycle
- in_pc  input  XLEN  PC of fetched instruction
- in_instr  input  XLEN  instruction word from instr_mem
- flush  input  1  discard all held and incoming entries
- out_valid  output  1  head entry valid for decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  XLEN  head PC
- out_instr  output  XLEN  head instruction, NOP_INSTR when empty
- out_misaligned  output  1  head PC has in_pc[1:0] != 0
- occupancy  output  2  entries held (0, 1, 2)

## Operation
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: head entry (drives outputs) and skid entry; each holds pc, instr, misaligned, valid.
- States, encoded by occupancy: EMPTY(0), ONE(1), FULL(2).
- EMPTY: accept -> ONE, head <= input. Otherwise stay.
- ONE: accept & pop -> ONE, head <= input. accept & !pop -> FULL, skid <= input. !accept & pop -> EMPTY. Neither -> hold.
- FULL: in_ready = 0, no accept. pop -> ONE, head <= skid. Otherwise hold.
- flush, any state: next state EMPTY and both valids cleared. The input is dropped even if in_valid=1. A pop in the same cycle still counts as consumed by decode.
- reset outranks flush. flush outranks accept and pop-driven transitions.
- out_misaligned = in_pc[1:0] != 0, captured at accept. The buffer does not block misaligned entries; decode raises the exception.
- Held entries never change while out_valid & !out_ready: pc, instr and misaligned are stable.
- Invalid head: out_pc = 0, out_instr = NOP_INSTR, out_misaligned = 0.

## Timing
- Reset values: out_valid 0, out_pc 0, out_instr NOP_INSTR, out_misaligned 0, occupancy 0, in_ready 1. Skid cleared.
- Latency: a pair accepted in cycle N is on the outputs, with out_valid=1, in cycle N+1.
- in_ready is a registered signal equal to !skid.valid. It has no combinational path from out_ready. With a stalled decode, one extra entry is absorbed after the stall begins.
- Throughput: 1 entry/cycle sustained when out_ready is held at 1.
- After flush in cycle N: in cycle N+1 out_valid=0, occupancy=0, in_ready=1.
- Reset asserted mid-operation: in the next cycle all outputs take their reset values, regardless of other inputs.
- All state updates occur on the rising edge of clk. Outputs are driven directly from registers (no combinational input-to-output paths).

## Structure
- Shared package riscv_pkg holds:
  - XLEN
  - NOP_INSTR
  - the occupancy state encoding (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2)
  - a pipe-entry typedef {valid, pc, instr, misaligned}
- One sub-module, if_id_entry: a single loadable entry register with sync clear. It is instantiated twice (head and skid). Load and clear enables come from the control logic in if_id_buffer.
- Fetch stage integration: the fetch stage advances its PC only when in_ready = 1. Redirect logic drives flush together with the new nextPC.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_instr=32'h00000013, occupancy=0, in_ready=1.
- Streaming: out_ready=1, feed PC 0,4,8,12 with instr 32'h00500093.. -> each appears one cycle later in order; occupancy stays 1.
- Stall/skid: feed PC 0,4,8 with out_ready=0 from cycle 1 -> PC 0 held at head, PC 4 in skid, in_ready=0, occupancy=2, PC 8 not accepted. Release out_ready -> outputs PC 0, then 4, then 8, with no loss or duplication.
- Flush while FULL, with in_valid=1 and PC 16 on the input -> next cycle out_valid=0, occupancy=0, in_ready=1; PC 16 never appears at the output.
- Misaligned: accept in_pc=32'h00000006 -> out_misaligned=1 with out_pc=6. Next aligned entry -> out_misaligned=0.
- Reset during FULL with flush=1 -> reset values next cycle. The first accept afterwards appears after 1-cycle latency.
